// File: rtl/dp_corr_engine.sv
// dp_corr_engine: builds two I/Q constellation density histograms (stream A and
// stream B) over a fixed-length frame, then forms their bin-wise dot product one
// bin per cycle. In cross mode it computes sum A*B; in auto mode, sum A*A.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start, mode              frame request (accepted in idle), 0=cross 1=auto
//   in_valid, i_a/q_a/i_b/q_b  sample qualifier and the two I/Q streams
//   busy                     high while accumulating or running the MAC
//   result, result_valid     dot product of the last completed frame
//   result_ready             consumer acknowledge; returns the engine to idle
//   sat_flag                 a bin counter saturated during the frame behind result
module dp_corr_engine #(
    parameter int unsigned SAMPLE_W  = 6,
    parameter int unsigned MA_SIZE   = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned X_MIN_A   = 31,
    parameter int unsigned Y_MIN_A   = 23,
    parameter int unsigned X_MIN_B   = 31,
    parameter int unsigned Y_MIN_B   = 39,
    parameter int unsigned ACC_W     = 2 * CNT_W + $clog2(MA_SIZE * MA_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] i_a,
    input  logic [SAMPLE_W-1:0] q_a,
    input  logic [SAMPLE_W-1:0] i_b,
    input  logic [SAMPLE_W-1:0] q_b,
    output logic                busy,
    output logic [ACC_W-1:0]    result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                sat_flag
);

    localparam int unsigned NB    = MA_SIZE * MA_SIZE;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned FC_W  = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StAccum, StMac, StDone} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] bin_a_q [NB];
    logic [CNT_W-1:0] bin_b_q [NB];
    logic [FC_W-1:0]  frame_cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] result_q;
    logic             sat_q;
    logic             sat_flag_q;
    logic             mode_q;

    function automatic logic in_win(input logic [SAMPLE_W-1:0] i, input logic [SAMPLE_W-1:0] q,
                                    input int unsigned xm, input int unsigned ym);
        int unsigned iv;
        int unsigned qv;
        iv = 32'(i);
        qv = 32'(q);
        return (iv >= xm) && (iv < xm + MA_SIZE) && (qv >= ym) && (qv < ym + MA_SIZE);
    endfunction

    function automatic logic [IDX_W-1:0] bin_idx(input logic [SAMPLE_W-1:0] i,
                                                 input logic [SAMPLE_W-1:0] q,
                                                 input int unsigned xm, input int unsigned ym);
        int unsigned t;
        t = (32'(q) - ym) * MA_SIZE + (32'(i) - xm);
        return IDX_W'(t);
    endfunction

    logic             start_acc, sample_acc, last_sample, last_bin, handshake;
    logic             win_a, win_b;
    logic [IDX_W-1:0] idx_a, idx_b;
    logic [CNT_W-1:0] op_a, op_b;
    logic [2*CNT_W-1:0] prod;
    logic [ACC_W-1:0] acc_next;

    always_comb begin
        start_acc   = (state_q == StIdle) && start;
        sample_acc  = (state_q == StAccum) && in_valid;
        last_sample = sample_acc && (frame_cnt_q == FC_W'(FRAME_LEN - 1));
        last_bin    = (state_q == StMac) && (idx_q == IDX_W'(NB - 1));
        handshake   = (state_q == StDone) && result_ready;

        win_a = in_win(i_a, q_a, X_MIN_A, Y_MIN_A);
        win_b = in_win(i_b, q_b, X_MIN_B, Y_MIN_B);
        idx_a = bin_idx(i_a, q_a, X_MIN_A, Y_MIN_A);
        idx_b = bin_idx(i_b, q_b, X_MIN_B, Y_MIN_B);

        op_a = bin_a_q[idx_q];
        op_b = mode_q ? bin_a_q[idx_q] : bin_b_q[idx_q];
        prod = {{CNT_W{1'b0}}, op_a} * {{CNT_W{1'b0}}, op_b};
        // Bin 0 restarts the sum so no explicit accumulator clear is needed.
        acc_next = ((idx_q == '0) ? '0 : acc_q) + ACC_W'(prod);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_acc) state_d = StAccum;
            StAccum: if (last_sample) state_d = StMac;
            StMac:   if (last_bin) state_d = StDone;
            StDone:  if (handshake) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NB; k++) begin
                bin_a_q[k] <= '0;
                bin_b_q[k] <= '0;
            end
        end else if (start_acc) begin
            for (int k = 0; k < NB; k++) begin
                bin_a_q[k] <= '0;
                bin_b_q[k] <= '0;
            end
        end else if (sample_acc) begin
            if (win_a && (bin_a_q[idx_a] != CNT_MAX)) bin_a_q[idx_a] <= bin_a_q[idx_a] + 1'b1;
            if (win_b && (bin_b_q[idx_b] != CNT_MAX)) bin_b_q[idx_b] <= bin_b_q[idx_b] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            sat_q       <= 1'b0;
            sat_flag_q  <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            if (start_acc) begin
                frame_cnt_q <= '0;
                sat_q       <= 1'b0;
                sat_flag_q  <= 1'b0;
                mode_q      <= mode;
            end else if (sample_acc) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                if ((win_a && (bin_a_q[idx_a] == CNT_MAX)) ||
                    (win_b && (bin_b_q[idx_b] == CNT_MAX))) begin
                    sat_q <= 1'b1;
                end
            end
            if (last_sample) begin
                idx_q <= '0;
            end else if (state_q == StMac) begin
                idx_q <= idx_q + 1'b1;
                acc_q <= acc_next;
            end
            if (last_bin) begin
                result_q   <= acc_next;
                sat_flag_q <= sat_q;
            end
        end
    end

    assign busy         = (state_q == StAccum) || (state_q == StMac);
    assign result_valid = (state_q == StDone);
    assign result       = result_q;
    assign sat_flag     = sat_flag_q;

endmodule

// File: tb/tb_dp_corr_engine.sv
// Testbench for dp_corr_engine: one instance with FRAME_LEN=8 for the main function,
// handshake and reset cases, and one with CNT_W=3/FRAME_LEN=10 for saturation.
module tb_dp_corr_engine;

    localparam int unsigned ACC0_W = 36;
    localparam int unsigned ACC1_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0 signals
    logic start0 = 0, mode0 = 0, in_valid0 = 0, rr0 = 0;
    logic [5:0] i_a0 = 0, q_a0 = 0, i_b0 = 0, q_b0 = 0;
    logic busy0, rv0, sat0;
    logic [ACC0_W-1:0] res0;

    // Instance 1 signals
    logic start1 = 0, mode1 = 0, in_valid1 = 0, rr1 = 0;
    logic [5:0] i_a1 = 0, q_a1 = 0, i_b1 = 0, q_b1 = 0;
    logic busy1, rv1, sat1;
    logic [ACC1_W-1:0] res1;

    dp_corr_engine #(.FRAME_LEN(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .in_valid(in_valid0),
        .i_a(i_a0), .q_a(q_a0), .i_b(i_b0), .q_b(q_b0), .busy(busy0), .result(res0),
        .result_valid(rv0), .result_ready(rr0), .sat_flag(sat0)
    );

    dp_corr_engine #(.CNT_W(3), .FRAME_LEN(10)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .in_valid(in_valid1),
        .i_a(i_a1), .q_a(q_a1), .i_b(i_b1), .q_b(q_b1), .busy(busy1), .result(res1),
        .result_valid(rv1), .result_ready(rr1), .sat_flag(sat1)
    );

    typedef struct {
        logic        mode;
        logic [5:0]  ia0, qa0, ia1, qa1;  // stream A, even / odd samples
        logic [5:0]  ib0, qb0, ib1, qb1;  // stream B, even / odd samples
        logic        gap;                 // 5 idle cycles before sample 4
        logic [35:0] exp_res;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[5];
    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one frame on instance 0 up to DONE and checks latency, result and sat_flag.
    task automatic frame0(input vec_t v, input string tag);
        int n;
        start0 = 1; mode0 = v.mode;
        tick();
        start0 = 0; mode0 = 0;
        check({tag, " busy after start"}, 64'(busy0), 64'd1);
        for (int s = 0; s < 8; s++) begin
            if (v.gap && s == 4) begin
                in_valid0 = 0;
                repeat (5) tick();
                check({tag, " busy in gap"}, 64'(busy0), 64'd1);
            end
            if (s % 2 == 0) begin
                i_a0 = v.ia0; q_a0 = v.qa0; i_b0 = v.ib0; q_b0 = v.qb0;
            end else begin
                i_a0 = v.ia1; q_a0 = v.qa1; i_b0 = v.ib1; q_b0 = v.qb1;
            end
            in_valid0 = 1;
            tick();
        end
        in_valid0 = 0;
        n = 0;
        while (!rv0 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd16);
        check({tag, " result"}, 64'(res0), 64'(v.exp_res));
        check({tag, " sat_flag"}, 64'(sat0), 64'(v.exp_sat));
        check({tag, " busy in done"}, 64'(busy0), 64'd0);
    endtask

    task automatic ack0(input string tag);
        rr0 = 1;
        tick();
        rr0 = 0;
        check({tag, " valid after ack"}, 64'(rv0), 64'd0);
    endtask

    task automatic frame1(input logic [5:0] ia_odd, input logic [5:0] ib_odd,
                          input logic [9:0] exp_res, input logic exp_sat, input string tag);
        int n;
        start1 = 1;
        tick();
        start1 = 0;
        check({tag, " sat cleared at start"}, 64'(sat1), 64'd0);
        for (int s = 0; s < 10; s++) begin
            i_a1 = (s % 2 == 0) ? 6'd31 : ia_odd; q_a1 = 6'd23;
            i_b1 = (s % 2 == 0) ? 6'd31 : ib_odd; q_b1 = 6'd39;
            in_valid1 = 1;
            tick();
        end
        in_valid1 = 0;
        n = 0;
        while (!rv1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd16);
        check({tag, " result"}, 64'(res1), 64'(exp_res));
        check({tag, " sat_flag"}, 64'(sat1), 64'(exp_sat));
        rr1 = 1;
        tick();
        rr1 = 0;
        check({tag, " valid after ack"}, 64'(rv1), 64'd0);
    endtask

    initial begin
        //          mode  A even    A odd     B even    B odd     gap result sat
        vecs[0] = '{1'b0, 31, 23, 31, 23, 31, 39, 31, 39, 1'b0, 36'd64, 1'b0};
        vecs[1] = '{1'b1, 31, 23, 34, 26, 0, 0, 5, 60, 1'b0, 36'd32, 1'b0};
        vecs[2] = '{1'b0, 30, 23, 35, 26, 31, 39, 31, 39, 1'b1, 36'd0, 1'b0};
        vecs[3] = '{1'b0, 31, 23, 34, 26, 31, 39, 34, 42, 1'b0, 36'd32, 1'b0};
        vecs[4] = '{1'b1, 32, 24, 32, 24, 31, 39, 31, 39, 1'b1, 36'd64, 1'b0};

        #2;
        check("reset busy", 64'(busy0), 64'd0);
        check("reset valid", 64'(rv0), 64'd0);
        check("reset result", 64'(res0), 64'd0);
        check("reset sat", 64'(sat0), 64'd0);
        @(negedge clk);
        rst = 0;
        tick();
        check("idle ignores in_valid", 64'(busy0), 64'd0);

        for (int k = 0; k < 5; k++) begin
            frame0(vecs[k], $sformatf("vec%0d", k));
            ack0($sformatf("vec%0d", k));
        end

        // DONE holds while result_ready is low; start pulses are ignored.
        frame0(vecs[0], "hold");
        for (int k = 0; k < 20; k++) begin
            start0 = (k % 3 == 0);
            tick();
            check("hold valid", 64'(rv0), 64'd1);
            check("hold result", 64'(res0), 64'd64);
        end
        start0 = 1; rr0 = 1;
        tick();
        start0 = 0; rr0 = 0;
        check("ack+start valid", 64'(rv0), 64'd0);
        check("ack+start busy", 64'(busy0), 64'd0);
        repeat (2) tick();
        check("no frame after ack+start", 64'(busy0), 64'd0);
        check("result kept in idle", 64'(res0), 64'd64);
        frame0(vecs[1], "second start");
        ack0("second start");

        // Saturation on the narrow-counter instance, then a clean frame.
        frame1(6'd31, 6'd31, 10'd49, 1'b1, "sat");
        frame1(6'd0, 6'd0, 10'd25, 1'b0, "clean");

        // Reset in MAC at bin index 7.
        start0 = 1; mode0 = 0;
        tick();
        start0 = 0;
        i_a0 = 31; q_a0 = 23; i_b0 = 31; q_b0 = 39;
        in_valid0 = 1;
        repeat (8) tick();
        in_valid0 = 0;
        repeat (7) tick();
        check("pre-reset busy", 64'(busy0), 64'd1);
        rst = 1;
        #1;
        check("mid-mac rst busy", 64'(busy0), 64'd0);
        check("mid-mac rst valid", 64'(rv0), 64'd0);
        check("mid-mac rst result", 64'(res0), 64'd0);
        check("mid-mac rst sat", 64'(sat0), 64'd0);
        @(negedge clk);
        rst = 0;
        tick();
        frame0(vecs[3], "after rst");
        ack0("after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dp_corr_engine.md
Name: dp_corr_engine

Overview:
- Parametrised successor to the fixed 4x4 density-matrix + MAC datapath.
- Builds two I/Q constellation density histograms (stream A, stream B) over a programmable window and a fixed-length frame, then computes their bin-wise dot product sequentially.
- Adds frame control, start/done handshake, saturating counters, cross/auto mode and a parametric grid size.
- Sits between the I/Q sample pads and the output byte mux of the SDR top.

Parameters:
SAMPLE_W, 6, unsigned width of each I/Q sample
MA_SIZE, 4, grid dimension; the histogram has MA_SIZE*MA_SIZE bins
CNT_W, 16, bin counter width
FRAME_LEN, 256, accepted samples per frame (>=1)
X_MIN_A, 31, lowest I value binned for stream A
Y_MIN_A, 23, lowest Q value binned for stream A
X_MIN_B, 31, lowest I value binned for stream B
Y_MIN_B, 39, lowest Q value binned for stream B
ACC_W, 2*CNT_W+$clog2(MA_SIZE*MA_SIZE), result width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a frame
mode  in  1  0 = cross (sum A*B), 1 = auto (sum A*A); sampled on accepted start
in_valid  in  1  sample qualifier for both streams
i_a  in  SAMPLE_W  stream A in-phase
q_a  in  SAMPLE_W  stream A quadrature
i_b  in  SAMPLE_W  stream B in-phase
q_b  in  SAMPLE_W  stream B quadrature
busy  out  1  high in ACCUM and MAC
result  out  ACC_W  dot-product result
result_valid  out  1  result holds a completed frame
result_ready  in  1  consumer acknowledge
sat_flag  out  1  a counter saturated during the frame that produced result

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high. No other reset domain.
- Reset values: state IDLE, all bins 0, sample counter 0, bin index 0, accumulator 0. Outputs: busy=0, result=0, result_valid=0, sat_flag=0.
- FSM states: IDLE, ACCUM, MAC, DONE.
- IDLE:
  - start=1 latches mode, clears all bins, the sample counter and the internal saturation bit, then enters ACCUM next cycle.
  - in_valid is ignored.
- ACCUM:
  - Each in_valid cycle increments the sample counter.
  - For each stream independently, the sample is in-window when X_MIN<=i<X_MIN+MA_SIZE and Y_MIN<=q<Y_MIN+MA_SIZE.
  - An in-window sample increments bin[(q-Y_MIN)*MA_SIZE+(i-X_MIN)].
  - Out-of-window samples count toward the frame but touch no bin.
  - Counters saturate at 2^CNT_W-1. An increment attempt at max sets the saturation bit.
  - The FRAME_LEN-th accepted sample is binned, then the FSM enters MAC next cycle. Cycles without in_valid do not advance the frame.
- MAC:
  - One bin per cycle, index 0..MA_SIZE^2-1.
  - acc += A[k]*B[k] in cross mode, or A[k]*A[k] in auto mode. Products are unsigned with full 2*CNT_W width; the accumulator is ACC_W and cannot overflow.
  - The first MAC cycle uses acc=0.
  - After index MA_SIZE^2-1 the FSM enters DONE.
  - Latency: if the last sample is accepted in cycle t, result_valid rises at t+1+MA_SIZE^2.
- DONE:
  - result and sat_flag are stable and result_valid=1.
  - Handshake: result_valid&&result_ready in a cycle moves the FSM to IDLE next cycle, and result_valid drops.
  - result keeps its value until the next DONE.
  - sat_flag is cleared when the next frame starts.
- start is ignored in ACCUM, MAC and DONE, including when it coincides with the result_ready handshake. A new frame needs start in IDLE.
- busy = (state==ACCUM || state==MAC).
- rst asserted mid-frame aborts immediately to the reset values. No partial result is exposed.

Test Plan:
- Override FRAME_LEN=8. Start, mode=0, 8 valid samples with A=(31,23) and B=(31,39) -> bin0 counts 8/8, result=64, result_valid exactly 1+16 cycles after the 8th sample, sat_flag=0.
- FRAME_LEN=8, mode=1. A alternates (31,23)/(34,26), B arbitrary -> bin0=4, bin15=4, result=32.
- Out-of-window and gaps: samples at (30,23) and (35,26), plus in_valid low for 5 cycles mid-frame -> no bin changes, frame still ends after 8 valid samples, result=0.
- CNT_W=3, FRAME_LEN=10, all samples in bin0 for both streams -> bins stick at 7, result=49, sat_flag=1. The next clean frame shows sat_flag=0.
- Handshake/start interplay:
  - Hold result_ready=0 for 20 cycles in DONE -> result stable, result_valid stays 1, start pulses ignored.
  - Raise result_ready together with start -> IDLE next cycle with no new frame.
  - A second start then runs normally.
- Assert rst during MAC at bin index 7 -> all outputs return to 0 the same cycle. A following frame produces the correct result from cleared bins.
